// File: rtl/binarize_writeback.sv
// Binarizes signed accumulator beats against a threshold and packs 16 lanes per activation word.
// Optional BINARIZE_WB_ONES_COUNT_EN adds a saturating count of written one-bits.
module binarize_writeback #(
    parameter int ACC_W  = 12,
    parameter int ADDR_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    input  logic [3:0]              acc_lane,
    input  logic signed [ACC_W-1:0] acc_sum,
    input  logic signed [ACC_W-1:0] alpha_thresh,
    input  logic                    acc_last,
    output logic                    act_wr_en,
    output logic [ADDR_W-1:0]       act_wr_addr,
    output logic [15:0]             act_wr_data,
    output logic [15:0]             act_wr_mask,
    output logic                    idle,
    output logic                    done,
    output logic [7:0]              word_count
`ifdef BINARIZE_WB_ONES_COUNT_EN
    ,
    output logic [11:0]             ones_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [15:0]        pack_q, pack_d;
    logic [15:0]        mask_q, mask_d;
    logic [7:0]         wc_q, wc_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               idle_q, idle_d;
    logic               ready_q, ready_d;
    logic               wr_en_q, wr_en_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic [15:0]        wr_mask_q, wr_mask_d;

`ifdef BINARIZE_WB_ONES_COUNT_EN
    logic [11:0]        ones_q, ones_d;
    logic [12:0]        ones_sum;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pack_d  = pack_q;
        mask_d  = mask_q;
        wc_d    = wc_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef BINARIZE_WB_ONES_COUNT_EN
        ones_d   = ones_q;
        ones_sum = {1'b0, ones_q} + {8'd0, popcount16(pack_q & mask_q)};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    wc_d    = '0;
                    pack_d  = '0;
                    mask_d  = '0;
                    last_d  = 1'b0;
`ifdef BINARIZE_WB_ONES_COUNT_EN
                    ones_d  = '0;
`endif
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (acc_valid) begin
                    pack_d[acc_lane] = (acc_sum >= alpha_thresh);
                    mask_d[acc_lane] = 1'b1;
                    if ((acc_lane == 4'hF) || acc_last) begin
                        last_d  = acc_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                pack_d = '0;
                mask_d = '0;
                ptr_d  = ptr_q + 1'b1;
                if (wc_q != 8'hFF) begin
                    wc_d = wc_q + 8'd1;
                end
`ifdef BINARIZE_WB_ONES_COUNT_EN
                ones_d = (ones_sum > 13'd4095) ? 12'hFFF : ones_sum[11:0];
`endif
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state so they line up with state_q.
        idle_d    = (state_d == S_IDLE);
        ready_d   = (state_d == S_COLLECT);
        wr_en_d   = (state_d == S_WRITE);
        wr_data_d = wr_en_d ? pack_d : '0;
        wr_mask_d = wr_en_d ? mask_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            pack_q    <= '0;
            mask_q    <= '0;
            wc_q      <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
`ifdef BINARIZE_WB_ONES_COUNT_EN
            ones_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pack_q    <= pack_d;
            mask_q    <= mask_d;
            wc_q      <= wc_d;
            last_q    <= last_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
`ifdef BINARIZE_WB_ONES_COUNT_EN
            ones_q    <= ones_d;
`endif
        end
    end

    assign acc_ready   = ready_q;
    assign act_wr_en   = wr_en_q;
    assign act_wr_addr = ptr_q;
    assign act_wr_data = wr_data_q;
    assign act_wr_mask = wr_mask_q;
    assign idle        = idle_q;
    assign done        = done_q;
    assign word_count  = wc_q;
`ifdef BINARIZE_WB_ONES_COUNT_EN
    assign ones_count  = ones_q;
`endif

endmodule

// File: tb/tb_binarize_writeback.sv
// Directed self-checking bench for binarize_writeback (ones_count checks under BINARIZE_WB_ONES_COUNT_EN).
module tb_binarize_writeback;

    logic               clk;
    logic               rst;
    logic               start;
    logic [6:0]         base_addr;
    logic               acc_valid;
    logic               acc_ready;
    logic [3:0]         acc_lane;
    logic signed [11:0] acc_sum;
    logic signed [11:0] alpha_thresh;
    logic               acc_last;
    logic               act_wr_en;
    logic [6:0]         act_wr_addr;
    logic [15:0]        act_wr_data;
    logic [15:0]        act_wr_mask;
    logic               idle;
    logic               done;
    logic [7:0]         word_count;
`ifdef BINARIZE_WB_ONES_COUNT_EN
    logic [11:0]        ones_count;
`endif

    int checks = 0;
    int errors = 0;

    binarize_writeback #(.ACC_W(12), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_lane(acc_lane),
        .acc_sum(acc_sum), .alpha_thresh(alpha_thresh), .acc_last(acc_last),
        .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr),
        .act_wr_data(act_wr_data), .act_wr_mask(act_wr_mask),
        .idle(idle), .done(done), .word_count(word_count)
`ifdef BINARIZE_WB_ONES_COUNT_EN
        , .ones_count(ones_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [6:0] a);
        @(negedge clk);
        start     = 1'b1;
        base_addr = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for acc_ready, then presents one beat; returns 1ns after the transfer edge.
    task automatic beat(input logic [3:0] lane, input logic signed [11:0] sum,
                        input logic signed [11:0] thr, input logic last);
        int n;
        @(negedge clk);
        n = 0;
        while (!acc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!acc_ready) check("ready_timeout", 32'(acc_ready), 32'd1);
        acc_valid    = 1'b1;
        acc_lane     = lane;
        acc_sum      = sum;
        alpha_thresh = thr;
        acc_last     = last;
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
        acc_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; acc_valid = 1'b0;
        acc_lane = '0; acc_sum = '0; alpha_thresh = '0; acc_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(acc_ready), 32'd0);
        check("rst_wr_en", 32'(act_wr_en), 32'd0);
        check("rst_addr", 32'(act_wr_addr), 32'd0);
        check("rst_data", 32'(act_wr_data), 32'd0);
        check("rst_mask", 32'(act_wr_mask), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full word at base 5, sum = lane vs threshold 8.
        pulse_start(7'd5);
        check("start_idle", 32'(idle), 32'd0);
        check("start_ready", 32'(acc_ready), 32'd1);
        for (int i = 0; i < 16; i++) beat(4'(i), 12'(i), 12'sd8, 1'b0);
        check("full_wr_en", 32'(act_wr_en), 32'd1);
        check("full_addr", 32'(act_wr_addr), 32'd5);
        check("full_data", 32'(act_wr_data), 32'hFF00);
        check("full_mask", 32'(act_wr_mask), 32'hFFFF);
        check("full_ready", 32'(acc_ready), 32'd0);
        @(posedge clk); #1;
        check("full_post_wr_en", 32'(act_wr_en), 32'd0);
        check("full_post_data", 32'(act_wr_data), 32'd0);
        check("full_post_mask", 32'(act_wr_mask), 32'd0);
        check("full_post_wc", 32'(word_count), 32'd1);
        check("full_post_ready", 32'(acc_ready), 32'd1);
        check("full_post_done", 32'(done), 32'd0);

        // Partial last word continues the same layer at the next address.
        beat(4'd0, 12'sd3, 12'sd0, 1'b0);
        beat(4'd1, -12'sd1, 12'sd0, 1'b0);
        beat(4'd2, 12'sd0, 12'sd0, 1'b1);
        check("part_wr_en", 32'(act_wr_en), 32'd1);
        check("part_addr", 32'(act_wr_addr), 32'd6);
        check("part_data", 32'(act_wr_data), 32'h0005);
        check("part_mask", 32'(act_wr_mask), 32'h0007);
        @(posedge clk); #1;
        check("part_done", 32'(done), 32'd1);
        check("part_idle", 32'(idle), 32'd1);
        check("part_wc", 32'(word_count), 32'd2);
        check("part_wr_off", 32'(act_wr_en), 32'd0);
`ifdef BINARIZE_WB_ONES_COUNT_EN
        check("ones_10", 32'(ones_count), 32'd10);
`endif
        @(posedge clk); #1;
        check("part_done_pulse", 32'(done), 32'd0);

        // Address wrap from 127, with an ignored start mid-word.
        pulse_start(7'd127);
        for (int i = 0; i < 5; i++) beat(4'(i), 12'sd0, 12'sd0, 1'b0);
        pulse_start(7'd3);
        check("start_ign_ready", 32'(acc_ready), 32'd1);
        check("start_ign_idle", 32'(idle), 32'd0);
        for (int i = 5; i < 16; i++) beat(4'(i), 12'sd0, 12'sd0, 1'b0);
        check("wrap1_addr", 32'(act_wr_addr), 32'd127);
        check("wrap1_data", 32'(act_wr_data), 32'hFFFF);
        @(posedge clk); #1;
        check("wrap1_wc", 32'(word_count), 32'd1);
        check("wrap_ptr", 32'(act_wr_addr), 32'd0);
        for (int i = 0; i < 16; i++) beat(4'(i), -12'sd1, 12'sd0, (i == 15));
        check("wrap2_wr_en", 32'(act_wr_en), 32'd1);
        check("wrap2_addr", 32'(act_wr_addr), 32'd0);
        check("wrap2_data", 32'(act_wr_data), 32'h0000);
        check("wrap2_mask", 32'(act_wr_mask), 32'hFFFF);
        @(posedge clk); #1;
        check("wrap2_done", 32'(done), 32'd1);
        check("wrap2_wc", 32'(word_count), 32'd2);
`ifdef BINARIZE_WB_ONES_COUNT_EN
        check("ones_16", 32'(ones_count), 32'd16);
`endif

        // acc_valid while idle must not start anything.
        @(negedge clk);
        acc_valid = 1'b1; acc_lane = 4'hF; acc_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid_idle", 32'(idle), 32'd1);
        check("idle_valid_wr_en", 32'(act_wr_en), 32'd0);
        check("idle_valid_ready", 32'(acc_ready), 32'd0);
        acc_valid = 1'b0; acc_last = 1'b0;

        // Duplicate lane: later beat overwrites the bit.
        pulse_start(7'd10);
        beat(4'd4, 12'sd10, 12'sd0, 1'b0);
        beat(4'd4, -12'sd10, 12'sd0, 1'b0);
        beat(4'd4, -12'sd5, 12'sd0, 1'b1);
        check("dup_addr", 32'(act_wr_addr), 32'd10);
        check("dup_data", 32'(act_wr_data), 32'h0000);
        check("dup_mask", 32'(act_wr_mask), 32'h0010);
        @(posedge clk); #1;
        check("dup_done", 32'(done), 32'd1);
        check("dup_wc", 32'(word_count), 32'd1);

        // Reset during WRITE, with start asserted alongside.
        pulse_start(7'd20);
        for (int i = 0; i < 16; i++) beat(4'(i), 12'sd5, 12'sd0, 1'b0);
        check("rw_wr_en", 32'(act_wr_en), 32'd1);
        check("rw_addr", 32'(act_wr_addr), 32'd20);
        check("rw_data", 32'(act_wr_data), 32'hFFFF);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_addr = 7'd50;
        @(posedge clk); #1;
        check("rw_abort_wr_en", 32'(act_wr_en), 32'd0);
        check("rw_abort_idle", 32'(idle), 32'd1);
        check("rw_abort_wc", 32'(word_count), 32'd0);
        check("rw_abort_done", 32'(done), 32'd0);
        check("rw_abort_addr", 32'(act_wr_addr), 32'd0);
        check("rw_abort_ready", 32'(acc_ready), 32'd0);
`ifdef BINARIZE_WB_ONES_COUNT_EN
        check("rw_abort_ones", 32'(ones_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rw_post_idle", 32'(idle), 32'd1);
        check("rw_post_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
